rle_line_run_finder: RTL

Parametrised per-line run-length analyser for the vision pipeline, sitting between the per-pixel colour classifiers and the rover's target-tracking logic. Each of NCH binary mask channels is scanned per line for its longest run of set pixels. At end of line the block reports start column and length per channel, applying a minimum-size filter. An optional gap-merge mode bridges short dropouts inside a run.

---
 rtl/rle_pkg.sv | 19 +
 rtl/rle_run_tracker.sv | 116 +++++++++++
 rtl/rle_line_run_finder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared constants and width helper for the per-line run-length analyser.
// Optional gap-merge build is selected with RLE_GAP_MERGE_EN.
package rle_pkg;

  localparam int DEF_IMAGE_W  = 640;
  localparam int DEF_MIN_SIZE = 60;
  localparam int DEF_MAX_GAP  = 4;

  // Smallest n with 2**n >= value; 0 for value <= 1.
  function automatic int rle_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rle_run_tracker.sv
// One channel's current/best run state for a single image line.
// With RLE_GAP_MERGE_EN defined, zero gaps of up to MAX_GAP pixels are bridged.
module rle_run_tracker
  import rle_pkg::*;
#(
  parameter int W = 11
`ifdef RLE_GAP_MERGE_EN
  ,
  parameter int MAX_GAP = DEF_MAX_GAP
`endif
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         en_i,
  input  logic         clear_i,
  input  logic         last_i,
  input  logic [W-1:0] col_i,
  input  logic         pixel_i,
  output logic [W-1:0] best_start_o,
  output logic [W-1:0] best_len_o
);

  logic [W-1:0] curStart_q, curStart_d, curLen_q, curLen_d;
  logic [W-1:0] bestStart_q, bestStart_d, bestLen_q, bestLen_d;
  logic [W-1:0] baseCurStart, baseCurLen, baseBestStart, baseBestLen;
  logic         closeRun;

`ifdef RLE_GAP_MERGE_EN
  localparam int GW = (rle_clog2(MAX_GAP + 1) < 1) ? 1 : rle_clog2(MAX_GAP + 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(MAX_GAP);

  logic [GW-1:0] gap_q, gap_d, baseGap;
`endif

  // Start-of-frame clears the channel before this pixel is applied, so the
  // update is computed from a "base" state that is either the registers or zero.
  always_comb begin
    baseCurStart  = clear_i ? '0 : curStart_q;
    baseCurLen    = clear_i ? '0 : curLen_q;
    baseBestStart = clear_i ? '0 : bestStart_q;
    baseBestLen   = clear_i ? '0 : bestLen_q;
    curStart_d    = baseCurStart;
    curLen_d      = baseCurLen;
    bestStart_d   = baseBestStart;
    bestLen_d     = baseBestLen;
    closeRun      = 1'b0;
`ifdef RLE_GAP_MERGE_EN
    baseGap       = clear_i ? '0 : gap_q;
    gap_d         = baseGap;
`endif

    if (pixel_i) begin
      if (baseCurLen == '0) begin
        curStart_d = col_i;
        curLen_d   = W'(1);
      end else begin
`ifdef RLE_GAP_MERGE_EN
        curLen_d = baseCurLen + W'(baseGap) + W'(1);
        gap_d    = '0;
`else
        curLen_d = baseCurLen + W'(1);
`endif
      end
    end else begin
`ifdef RLE_GAP_MERGE_EN
      if (baseCurLen != '0) begin
        if (baseGap == GAP_LIMIT) closeRun = 1'b1;
        else                      gap_d    = baseGap + GW'(1);
      end
`else
      closeRun = 1'b1;
`endif
    end

    // Strict compare keeps the earliest run on ties.
    if (closeRun) begin
      if (baseCurLen > baseBestLen) begin
        bestStart_d = baseCurStart;
        bestLen_d   = baseCurLen;
      end
      curLen_d = '0;
`ifdef RLE_GAP_MERGE_EN
      gap_d    = '0;
`endif
    end

    // Line-final view: the open run closes as well, any pending gap excluded.
    best_start_o = bestStart_d;
    best_len_o   = bestLen_d;
    if (curLen_d > bestLen_d) begin
      best_start_o = curStart_d;
      best_len_o   = curLen_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || (en_i && last_i)) begin
      curStart_q  <= '0;
      curLen_q    <= '0;
      bestStart_q <= '0;
      bestLen_q   <= '0;
`ifdef RLE_GAP_MERGE_EN
      gap_q       <= '0;
`endif
    end else if (en_i) begin
      curStart_q  <= curStart_d;
      curLen_q    <= curLen_d;
      bestStart_q <= bestStart_d;
      bestLen_q   <= bestLen_d;
`ifdef RLE_GAP_MERGE_EN
      gap_q       <= gap_d;
`endif
    end
  end

endmodule

// File: rtl/rle_line_run_finder.sv
// Per-line longest-run finder over NCH binary mask channels with a minimum-size filter.
// Define RLE_GAP_MERGE_EN to bridge short zero dropouts inside a run.
module rle_line_run_finder
  import rle_pkg::*;
#(
  parameter int IMAGE_W  = DEF_IMAGE_W,
  parameter int NCH      = 4,
  parameter int W        = 11,
  parameter int LINE_W   = 10,
  parameter int MIN_SIZE = DEF_MIN_SIZE,
  parameter int MAX_GAP  = DEF_MAX_GAP
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              pix_valid,
  input  logic              sof,
  input  logic [NCH-1:0]    pix_in,
  output logic              line_done,
  output logic [LINE_W-1:0] line_idx,
  output logic [NCH-1:0]    run_found,
  output logic [NCH*W-1:0]  run_start,
  output logic [NCH*W-1:0]  run_len
);

  localparam logic [W-1:0] LAST_COL = W'(IMAGE_W - 1);
  localparam logic [W-1:0] MIN_LEN  = W'(MIN_SIZE);

  generate
    if (W < rle_clog2(IMAGE_W + 1) || MAX_GAP < 0) begin : g_param_check
      $error("rle_line_run_finder: W too narrow for IMAGE_W or MAX_GAP negative");
    end
  endgenerate

  logic [W-1:0]      col_q, col_d, colEff;
  logic [LINE_W-1:0] lineCnt_q, lineEff;
  logic              lastCol;

  logic              lineDone_q;
  logic [LINE_W-1:0] lineIdx_q;
  logic [NCH-1:0]    runFound_q, found_d;
  logic [NCH*W-1:0]  runStart_q, runLen_q, start_d, len_d;

  logic [W-1:0] bestStart [NCH];
  logic [W-1:0] bestLen   [NCH];

  // A qualified sof forces this pixel to column 0 of line 0.
  always_comb begin
    colEff  = sof ? '0 : col_q;
    lineEff = sof ? '0 : lineCnt_q;
    lastCol = (colEff == LAST_COL);
    col_d   = lastCol ? '0 : colEff + W'(1);
  end

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      rle_run_tracker #(
        .W       (W)
`ifdef RLE_GAP_MERGE_EN
        ,
        .MAX_GAP (MAX_GAP)
`endif
      ) u_tracker (
        .CLK          (CLK),
        .RESET        (RESET),
        .en_i         (pix_valid),
        .clear_i      (sof),
        .last_i       (lastCol),
        .col_i        (colEff),
        .pixel_i      (pix_in[c]),
        .best_start_o (bestStart[c]),
        .best_len_o   (bestLen[c])
      );
    end
  endgenerate

  always_comb begin
    found_d = '0;
    start_d = '0;
    len_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      found_d[i] = (bestLen[i] >= MIN_LEN);
      if (found_d[i]) begin
        start_d[i*W +: W] = bestStart[i];
        len_d[i*W +: W]   = bestLen[i];
      end
    end
  end

  // Results are registered only on the last column; line_done is a one-cycle pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      col_q      <= '0;
      lineCnt_q  <= '0;
      lineDone_q <= 1'b0;
      lineIdx_q  <= '0;
      runFound_q <= '0;
      runStart_q <= '0;
      runLen_q   <= '0;
    end else begin
      lineDone_q <= 1'b0;
      if (pix_valid) begin
        col_q <= col_d;
        if (lastCol) begin
          lineDone_q <= 1'b1;
          lineIdx_q  <= lineEff;
          runFound_q <= found_d;
          runStart_q <= start_d;
          runLen_q   <= len_d;
          lineCnt_q  <= lineEff + LINE_W'(1);
        end else begin
          lineCnt_q  <= lineEff;
        end
      end
    end
  end

  assign line_done = lineDone_q;
  assign line_idx  = lineIdx_q;
  assign run_found = runFound_q;
  assign run_start = runStart_q;
  assign run_len   = runLen_q;

endmodule
